// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the CORDIC request scheduler.
// The tag id is sized for the largest supported requester count (8).
package cordic_sched_pkg;

  localparam int CS_DATA_W   = 16;
  // Must match the cordic stage count: its 128-bit stage buses hold 8 x 16-bit stages.
  localparam int CS_PIPE_LAT = 8;
  localparam int TAG_ID_W    = 3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr_i, first valid request wins.
// The pointer register lives in the parent; gnt_idx_o is the next pointer value on accept.
module rr_arbiter
  import cordic_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  int            cand;
  logic [IW-1:0] cidx;
  logic          found;

  always_comb begin
    grant_o   = '0;
    gnt_idx_o = ptr_i;
    found     = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cidx = IW'(cand);
      if (en_i && !found && req_i[cidx]) begin
        found          = 1'b1;
        grant_o[cidx]  = 1'b1;
        gnt_idx_o      = cidx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one pipelined cordic among NUM_REQ requesters; round-robin grant, tag pipe routes results back.
// Accept-to-response latency is PIPE_LAT cycles; no response backpressure, hold only blocks new grants.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = CS_DATA_W,
  parameter int PIPE_LAT = CS_PIPE_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_z,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_res1,
  output logic [DATA_W-1:0]         resp_res2,
  output logic                      cor_mode,
  output logic [DATA_W-1:0]         cor_x,
  output logic [DATA_W-1:0]         cor_y,
  output logic [DATA_W-1:0]         cor_z,
  input  logic [DATA_W-1:0]         cor_res1,
  input  logic [DATA_W-1:0]         cor_res2,
  output logic                      busy,
  output logic [15:0]               issue_cnt
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               accept;

  logic               cor_mode_q, cor_mode_d;
  logic [DATA_W-1:0]  cor_x_q, cor_x_d;
  logic [DATA_W-1:0]  cor_y_q, cor_y_d;
  logic [DATA_W-1:0]  cor_z_q, cor_z_d;
  logic [15:0]        issue_cnt_q, issue_cnt_d;
  tag_t               tag_q [PIPE_LAT];
  tag_t               tag_in_d;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .en_i      (!hold && !reset),
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (accept)
  );

  assign req_ready = gnt;

  // Grant is one-hot, so the operand select is a plain AND-OR mux.
  always_comb begin
    cor_mode_d = cor_mode_q;
    cor_x_d    = cor_x_q;
    cor_y_d    = cor_y_q;
    cor_z_d    = cor_z_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        cor_mode_d = req_mode[i];
        cor_x_d    = req_x[i*DATA_W +: DATA_W];
        cor_y_d    = req_y[i*DATA_W +: DATA_W];
        cor_z_d    = req_z[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d          = accept ? gnt_idx : ptr_q;
    issue_cnt_d    = accept ? issue_cnt_q + 16'd1 : issue_cnt_q;
    tag_in_d.valid = accept;
    tag_in_d.id    = TAG_ID_W'(gnt_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      cor_mode_q  <= 1'b0;
      cor_x_q     <= '0;
      cor_y_q     <= '0;
      cor_z_q     <= '0;
      issue_cnt_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cor_mode_q  <= cor_mode_d;
      cor_x_q     <= cor_x_d;
      cor_y_q     <= cor_y_d;
      cor_z_q     <= cor_z_d;
      issue_cnt_q <= issue_cnt_d;
      tag_q[0]    <= tag_in_d;
      for (int k = 1; k < PIPE_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    resp_valid = '0;
    busy       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = tag_q[PIPE_LAT-1].valid && (tag_q[PIPE_LAT-1].id == TAG_ID_W'(i));
    for (int k = 0; k < PIPE_LAT; k++)
      busy = busy | tag_q[k].valid;
  end

  assign resp_res1 = cor_res1;
  assign resp_res2 = cor_res2;
  assign cor_mode  = cor_mode_q;
  assign cor_x     = cor_x_q;
  assign cor_y     = cor_y_q;
  assign cor_z     = cor_z_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with an identity cordic model (res1=x, res2=z).
// Expected responses are queued at grant time and matched cycle-exactly by a monitor.
module tb_cordic_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PL = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_mode;
  logic [N*DW-1:0] req_x, req_y, req_z;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_res1, resp_res2;
  logic            cor_mode;
  logic [DW-1:0]   cor_x, cor_y, cor_z;
  logic [DW-1:0]   cor_res1, cor_res2;
  logic            busy;
  logic [15:0]     issue_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit mon_en      = 1'b0;

  typedef struct {
    int          id;
    logic [15:0] r1;
    logic [15:0] r2;
    int          due;
  } exp_t;
  exp_t sb[$];

  cordic_scheduler #(.NUM_REQ(N), .DATA_W(DW), .PIPE_LAT(PL)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_z      (req_z),
    .resp_valid (resp_valid),
    .resp_res1  (resp_res1),
    .resp_res2  (resp_res2),
    .cor_mode   (cor_mode),
    .cor_x      (cor_x),
    .cor_y      (cor_y),
    .cor_z      (cor_z),
    .cor_res1   (cor_res1),
    .cor_res2   (cor_res2),
    .busy       (busy),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The scheduler's operand register is the first cordic stage, so the model adds PL-1 more.
  logic [DW-1:0] dl1 [PL-1];
  logic [DW-1:0] dl2 [PL-1];
  always @(posedge clk) begin
    dl1[0] <= cor_x;
    dl2[0] <= cor_z;
    for (int k = 1; k < PL-1; k++) begin
      dl1[k] <= dl1[k-1];
      dl2[k] <= dl2[k-1];
    end
  end
  assign cor_res1 = dl1[PL-2];
  assign cor_res2 = dl2[PL-2];

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_t e;
        logic [N-1:0] oh;
        e  = sb.pop_front();
        oh = N'(1) << e.id;
        vectors++;
        assert (resp_valid === oh) else begin
          miscompares++;
          $error("FAIL resp_valid observed=%b expected=%b cyc=%0d", resp_valid, oh, cyc);
        end
        vectors++;
        assert (resp_res1 === e.r1) else begin
          miscompares++;
          $error("FAIL resp_res1 observed=%h expected=%h cyc=%0d", resp_res1, e.r1, cyc);
        end
        vectors++;
        assert (resp_res2 === e.r2) else begin
          miscompares++;
          $error("FAIL resp_res2 observed=%h expected=%h cyc=%0d", resp_res2, e.r2, cyc);
        end
      end else begin
        vectors++;
        assert (resp_valid === '0) else begin
          miscompares++;
          $error("FAIL no_resp observed=%b expected=%b cyc=%0d", resp_valid, {N{1'b0}}, cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic m, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] z);
    req_mode[i]        = m;
    req_x[i*DW +: DW]  = x;
    req_y[i*DW +: DW]  = y;
    req_z[i*DW +: DW]  = z;
  endtask

  // Called at a negedge with inputs already driven; checks the grant and advances one cycle.
  task automatic cycle_chk(input int exp_idx, input bit push);
    logic [N-1:0] exp_rdy;
    exp_t         e;
    #1;
    exp_rdy = (exp_idx >= 0) ? (N'(1) << exp_idx) : '0;
    vectors++;
    assert (req_ready === exp_rdy) else begin
      miscompares++;
      $error("FAIL grant observed=%b expected=%b cyc=%0d", req_ready, exp_rdy, cyc);
    end
    if (push && exp_idx >= 0) begin
      e.id  = exp_idx;
      e.r1  = req_x[exp_idx*DW +: DW];
      e.r2  = req_z[exp_idx*DW +: DW];
      e.due = cyc + PL;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL drain_timeout observed=%0d expected=0 pending", sb.size());
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hold = 1'b0;
    req_valid = '1; req_mode = '0; req_x = '0; req_y = '0; req_z = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_cor_x", cor_x, 16'h0);
    chk("rst_cor_z", cor_z, 16'h0);
    chk("rst_cor_mode", 16'(cor_mode), 16'h0);
    chk("rst_issue_cnt", issue_cnt, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_resp_valid", 16'(resp_valid), 16'h0);
    req_valid = '0;
    reset     = 1'b0;
    mon_en    = 1'b1;
    @(negedge clk);

    // Single op from requester 0.
    set_op(0, 1'b1, 16'h1A60, 16'h0E00, 16'h0200);
    req_valid = 4'b0001;
    cycle_chk(0, 1'b1);
    req_valid = '0;
    chk("single_issue_cnt", issue_cnt, 16'h0001);
    chk("single_cor_mode", 16'(cor_mode), 16'h0001);
    chk("single_cor_x", cor_x, 16'h1A60);
    chk("single_cor_y", cor_y, 16'h0E00);
    chk("single_cor_z", cor_z, 16'h0200);
    chk("single_busy", 16'(busy), 16'h0001);
    drain();

    // Round robin with all four requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i[0], 16'h1000 | 16'(i), 16'h0, 16'h8000 | 16'(i));
    req_valid = '1;
    for (int k = 0; k < 8; k++) cycle_chk(k % N, 1'b1);
    req_valid = '0;
    chk("rr_issue_cnt", issue_cnt, 16'd8);
    repeat (7) @(negedge clk);
    chk("rr_busy_last", 16'(busy), 16'h0001);
    @(negedge clk);
    chk("rr_busy_fall", 16'(busy), 16'h0000);
    drain();

    // Hold blocks grants; pointer is at 3 so requester 2 wins once released.
    hold = 1'b1;
    set_op(2, 1'b0, 16'h2BCD, 16'h0011, 16'h8123);
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) cycle_chk(-1, 1'b0);
    hold = 1'b0;
    cycle_chk(2, 1'b1);
    req_valid = '0;
    drain();

    // Reset with three ops in flight: none of them may respond.
    set_op(1, 1'b0, 16'h0AAA, 16'h0BBB, 16'h0CCC);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) cycle_chk(1, 1'b0);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", 16'(busy), 16'h0000);
    chk("mid_issue_cnt", issue_cnt, 16'h0000);
    set_op(0, 1'b1, 16'h0123, 16'h0456, 16'h0789);
    req_valid = 4'b0011;
    cycle_chk(0, 1'b1);
    req_valid = '0;
    drain();

    // Counter wrap.
    force dut.issue_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.issue_cnt_q;
    set_op(3, 1'b0, 16'h7777, 16'h0001, 16'h8888);
    req_valid = 4'b1000;
    cycle_chk(3, 1'b1);
    req_valid = '0;
    chk("wrap_issue_cnt", issue_cnt, 16'h0000);
    drain();

    // Bubble between two accepts; cor_* must hold across the idle edge.
    set_op(1, 1'b1, 16'h1111, 16'h0000, 16'h2222);
    req_valid = 4'b0010;
    cycle_chk(1, 1'b1);
    req_valid = '0;
    set_op(1, 1'b0, 16'h3333, 16'h0001, 16'h6666);
    chk("bubble_cor_x_c1", cor_x, 16'h1111);
    cycle_chk(-1, 1'b0);
    chk("bubble_cor_x_c2", cor_x, 16'h1111);
    chk("bubble_cor_z_c2", cor_z, 16'h2222);
    set_op(1, 1'b0, 16'h4444, 16'h0002, 16'h5555);
    req_valid = 4'b0010;
    cycle_chk(1, 1'b1);
    req_valid = '0;
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
